// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared opcode and FSM state encodings for the calculator front end
// Revision : 1.0  initial release
// ============================================================================
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } calc_state_t;

endpackage
`default_nettype wire

// File: rtl/calc_iter_counter.sv
`default_nettype none
// ============================================================================
// Module   : calc_iter_counter
// Purpose  : Saturating iteration counter for the multi-cycle MUL/DIV sequences
// Revision : 1.0  initial release
// ============================================================================
module calc_iter_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    assign last = (cnt == C_LAST);

    // Holds at the final index so the debug step output never wraps
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !last) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_op_sequencer
// Purpose  : Request/response sequencer for add, sub, shift-add mul, restoring div
// Revision : 1.0  initial release
// ============================================================================
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int   WIDTH = 8,
    localparam int  CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic               rsp_div0,
    output logic               busy,
    output logic [CNT_W-1:0]   step
);

    calc_state_t          r_state;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_accept;
    logic                 w_last;
    logic [CNT_W-1:0]     w_step;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_mul_hi;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH-1:0]     w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_result;

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign step      = w_step;

    calc_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_accept),
        .en   (r_state == ST_EXEC),
        .cnt  (w_step),
        .last (w_last)
    );

    // MUL: r_acc = {partial product, remaining multiplier bits}
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_mul_hi   = r_acc[0] ? w_mul_sum : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_mul_next = {w_mul_hi, r_acc[WIDTH-1:1]};

    // DIV: r_acc = {partial remainder, dividend bits shifting into quotient}
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;
    assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    always_comb begin
        w_result = r_acc;
        case (r_op)
            OP_ADD:  w_result = {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
            OP_SUB:  w_result = {{WIDTH{1'b0}}, r_a} - {{WIDTH{1'b0}}, r_b};
            default: w_result = r_acc;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_div0   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op     <= req_op;
                        r_a      <= req_a;
                        r_b      <= req_b;
                        rsp_div0 <= 1'b0;
                        case (req_op)
                            OP_MUL: begin
                                r_acc   <= {{WIDTH{1'b0}}, req_b};
                                r_state <= ST_EXEC;
                            end
                            OP_DIV: begin
                                if (req_b == '0) begin
                                    r_acc   <= {req_a, {WIDTH{1'b1}}};
                                    r_state <= ST_DONE;
                                end else begin
                                    r_acc   <= {{WIDTH{1'b0}}, req_a};
                                    r_state <= ST_EXEC;
                                end
                            end
                            default: r_state <= ST_DONE;
                        endcase
                    end
                end
                ST_EXEC: begin
                    r_acc <= (r_op == OP_MUL) ? w_mul_next : w_div_next;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle registers the response; later cycles wait for the consumer
                    if (!rsp_valid) begin
                        rsp_valid  <= 1'b1;
                        rsp_result <= w_result;
                        rsp_div0   <= (r_op == OP_DIV) && (r_b == '0);
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_op_sequencer
// Purpose  : Directed self-checking bench for calc_op_sequencer (WIDTH=8)
// Revision : 1.0  initial release
// ============================================================================
module tb_calc_op_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic               clk;
    logic               rstn;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*WIDTH-1:0] rsp_result;
    logic               rsp_div0;
    logic               busy;
    logic [CNT_W-1:0]   step;

    int n_chk;
    int n_pass;
    int lat;

    calc_op_sequencer #(.WIDTH(WIDTH)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_div0   (rsp_div0),
        .busy       (busy),
        .step       (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns just after the accept edge
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (!rsp_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid",  {31'd0, rsp_valid}, 32'd0);
        chk("rst_result", {16'd0, rsp_result}, 32'd0);
        chk("rst_div0",   {31'd0, rsp_div0}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_step",   {29'd0, step}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready",  {31'd0, req_ready}, 32'd1);

        // ADD 200+100
        issue(2'b00, 8'd200, 8'd100);
        wait_rsp(lat);
        chk("add_lat",  lat, 32'd1);
        chk("add_res",  {16'd0, rsp_result}, 32'h012C);
        chk("add_div0", {31'd0, rsp_div0}, 32'd0);
        handshake();

        // SUB both signs
        issue(2'b01, 8'd5, 8'd9);
        wait_rsp(lat);
        chk("sub_neg_res", {16'd0, rsp_result}, 32'hFFFC);
        handshake();
        issue(2'b01, 8'd9, 8'd5);
        wait_rsp(lat);
        chk("sub_pos_res", {16'd0, rsp_result}, 32'h0004);
        handshake();

        // MUL 255*255 with step/busy trace
        issue(2'b10, 8'd255, 8'd255);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("mul_step",  {29'd0, step}, (k < 7) ? k : 7);
            chk("mul_busy",  {31'd0, busy}, 32'd1);
            chk("mul_early", {31'd0, rsp_valid}, 32'd0);
        end
        @(negedge clk);
        chk("mul_valid9", {31'd0, rsp_valid}, 32'd1);
        chk("mul_res",    {16'd0, rsp_result}, 32'hFE01);
        handshake();

        // DIV 200/7 and divide by zero
        issue(2'b11, 8'd200, 8'd7);
        wait_rsp(lat);
        chk("div_lat",  lat, 32'd9);
        chk("div_res",  {16'd0, rsp_result}, 32'h041C);
        chk("div_div0", {31'd0, rsp_div0}, 32'd0);
        handshake();
        issue(2'b11, 8'd13, 8'd0);
        wait_rsp(lat);
        chk("div0_lat",  lat, 32'd1);
        chk("div0_res",  {16'd0, rsp_result}, 32'h0DFF);
        chk("div0_flag", {31'd0, rsp_div0}, 32'd1);
        handshake();

        // Backpressure, ignored request in DONE, back-to-back accept
        issue(2'b10, 8'd12, 8'd11);
        wait_rsp(lat);
        chk("bp_lat",  lat, 32'd9);
        chk("bp_res",  {16'd0, rsp_result}, 32'h0084);
        chk("bp_div0", {31'd0, rsp_div0}, 32'd0);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 8'd3;
        req_b     = 8'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold",  {16'd0, rsp_result}, 32'h0084);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("b2b_drop",  {31'd0, rsp_valid}, 32'd0);
        chk("b2b_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_busy",  {31'd0, busy}, 32'd1);
        chk("b2b_nrdy",  {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_res",   {16'd0, rsp_result}, 32'h0007);
        handshake();

        // Reset in the middle of a MUL
        issue(2'b10, 8'd3, 8'd5);
        repeat (4) @(negedge clk);
        chk("mr_step3", {29'd0, step}, 32'd3);
        rstn = 1'b0;
        #1;
        chk("mr_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mr_busy",  {31'd0, busy}, 32'd0);
        chk("mr_step",  {29'd0, step}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        issue(2'b00, 8'd1, 8'd1);
        wait_rsp(lat);
        chk("mr_add_lat", lat, 32'd1);
        chk("mr_add_res", {16'd0, rsp_result}, 32'h0002);
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
